// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank sequencer: FSM state encoding and access direction.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic RD = 1'b0;
   localparam logic WR = 1'b1;

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Requester-side bus of the register-bank sequencer: flattened per-requester requests and responses.
interface reg_bank_sequencer_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_REQ-1:0]        grant;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  ack, rdata, grant
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output ack, rdata, grant
   );

endinterface

// File: rtl/reg_bank_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr, with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      logic found;
      int   idx;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Round-robin sequencer for a shared bank of tri-state register cells; all state advances on Tick.
// Optional bank-wide preset request is enabled with `define REG_BANK_PRESET_EN.
//
// state  | meaning
// IDLE   | arbitrate requests (preset first when enabled), latch the winner
// ACCESS | one cell enabled: reg_ce for a write, reg_cs low for a read
// RESP   | ack pulse to the winner (or reg_pre pulse), advance rr pointer
module reg_bank_sequencer
   import reg_bank_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Tick,
`ifdef REG_BANK_PRESET_EN
   input  logic                preset_req,
`endif
   reg_bank_sequencer_if.slave bus,
   output logic [DATA_W-1:0]   bank_wdata,
   input  logic [DATA_W-1:0]   bank_rdata,
   output logic [NUM_REGS-1:0] reg_cs,
   output logic [NUM_REGS-1:0] reg_ce,
   output logic                bank_tick,
   output logic                reg_pre
);

   localparam int PW = $clog2(NUM_REQ);

   state_t              state_q, state_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d, win_q, win_d;
   logic                lat_we_q, lat_we_d, lat_ok_q, lat_ok_d, pre_q, pre_d;
   logic [NUM_REQ-1:0]  arb_gnt, grant_q, grant_d, ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
   logic [NUM_REGS-1:0] cs_q, cs_d, ce_q, ce_d;

   logic                preset_go;
   logic                sel_we, sel_ok;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [PW-1:0]       sel_idx;
   logic [NUM_REGS-1:0] sel_dec;

`ifdef REG_BANK_PRESET_EN
   assign preset_go = preset_req;
`else
   assign preset_go = 1'b0;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .grant (arb_gnt)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_we    = bus.req_we[i];
            sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            sel_idx   = PW'(i);
         end
      end
      sel_ok = int'(sel_addr) < NUM_REGS;
      // out-of-range addresses decode to no cell at all
      for (int r = 0; r < NUM_REGS; r++) sel_dec[r] = (int'(sel_addr) == r);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         lat_we_q <= RD;
         lat_ok_q <= 1'b0;
         pre_q    <= 1'b0;
         grant_q  <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         wdata_q  <= '0;
         cs_q     <= '1;
         ce_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         lat_we_q <= lat_we_d;
         lat_ok_q <= lat_ok_d;
         pre_q    <= pre_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         rdata_q  <= rdata_d;
         wdata_q  <= wdata_d;
         cs_q     <= cs_d;
         ce_q     <= ce_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (Tick) begin
         case (state_q)
            IDLE:    if (preset_go) state_d = RESP;
                     else if (|bus.req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      lat_we_d = lat_we_q;
      lat_ok_d = lat_ok_q;
      pre_d    = pre_q;
      grant_d  = grant_q;
      ack_d    = ack_q;
      rdata_d  = rdata_q;
      wdata_d  = wdata_q;
      cs_d     = cs_q;
      ce_d     = ce_q;
      if (Tick) begin
         case (state_q)
            IDLE: begin
               if (preset_go) begin
                  pre_d = 1'b1;
               end else if (|bus.req) begin
                  grant_d  = arb_gnt;
                  win_d    = sel_idx;
                  lat_we_d = sel_we;
                  lat_ok_d = sel_ok;
                  if (sel_we == WR) begin
                     ce_d    = sel_dec;
                     wdata_d = sel_wdata;
                  end else begin
                     cs_d = ~sel_dec;
                  end
               end
            end
            ACCESS: begin
               ce_d    = '0;
               cs_d    = '1;
               wdata_d = '0;
               ack_d   = grant_q;
               if (lat_we_q == RD) rdata_d = lat_ok_q ? bank_rdata : '0;
            end
            RESP: begin
               ack_d   = '0;
               grant_d = '0;
               pre_d   = 1'b0;
               // a preset cycle leaves the round-robin position untouched
               if (!pre_q) rr_ptr_d = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ack    = ack_q;
   assign bus.grant  = grant_q;
   assign bus.rdata  = rdata_q;
   assign bank_wdata = wdata_q;
   assign reg_cs     = cs_q;
   assign reg_ce     = ce_q;
   assign reg_pre    = pre_q;
   assign bank_tick  = Tick;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Scoreboard bench for reg_bank_sequencer with a behavioural register-cell model on the bank side.
module tb_reg_bank_sequencer;

   localparam int NR = 4;
   localparam int NG = 8;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Tick;
   logic [DW-1:0] bank_wdata, bank_rdata;
   logic [NG-1:0] reg_cs, reg_ce;
   logic          bank_tick, reg_pre;
`ifdef REG_BANK_PRESET_EN
   logic          preset_req;
`endif

   reg_bank_sequencer_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   reg_bank_sequencer #(.NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(AW), .DATA_W(DW)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Tick       (Tick),
`ifdef REG_BANK_PRESET_EN
      .preset_req (preset_req),
`endif
      .bus        (bus),
      .bank_wdata (bank_wdata),
      .bank_rdata (bank_rdata),
      .reg_cs     (reg_cs),
      .reg_ce     (reg_ce),
      .bank_tick  (bank_tick),
      .reg_pre    (reg_pre)
   );

   always #5 Clock = ~Clock;

   // cells capture on Tick edges; an undriven bus reads back as 0x5A
   logic [DW-1:0] mem [NG];
   always @(posedge Clock) begin
      if (Tick) begin
         for (int r = 0; r < NG; r++) begin
            if (reg_pre) mem[r] <= 8'hFF;
            else if (reg_ce[r]) mem[r] <= bank_wdata;
         end
      end
   end
   always_comb begin
      bank_rdata = 8'h5A;
      for (int r = 0; r < NG; r++) if (!reg_cs[r]) bank_rdata = mem[r];
   end

   typedef struct {
      int          id;
      bit          rd;
      logic [7:0]  data;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [NR-1:0] ack_prev = '0;
   always @(negedge Clock) begin
      exp_t e;
      if (Reset) begin
         ack_prev = '0;
      end else begin
         check("cs_at_most_one_low", 32'($countones(~reg_cs) <= 1), 1);
         check("ce_at_most_one_high", 32'($countones(reg_ce) <= 1), 1);
         check("bank_tick", 32'(bank_tick), 32'(Tick));
         if (bus.ack != '0 && ack_prev == '0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got %b expected none", bus.ack);
            end else begin
               e = sb.pop_front();
               check("sb_ack", 32'(bus.ack), 32'(1) << e.id);
               if (e.rd) check("sb_rdata", 32'(bus.rdata), 32'(e.data));
            end
         end
         ack_prev = bus.ack;
      end
   end

   task automatic set_req(int id, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
      bus.req[id]                = 1'b1;
      bus.req_we[id]             = we;
      bus.req_addr[id*AW +: AW]  = addr;
      bus.req_wdata[id*DW +: DW] = wd;
   endtask

   task automatic txn(int id, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                      logic [DW-1:0] exp_rd, logic [NG-1:0] exp_ce, logic [NG-1:0] exp_cs);
      sb.push_back('{id, !we, exp_rd});
      set_req(id, we, addr, wd);
      @(negedge Clock);
      check("grant", 32'(bus.grant), 32'(1) << id);
      check("reg_ce_access", 32'(reg_ce), 32'(exp_ce));
      check("reg_cs_access", 32'(reg_cs), 32'(exp_cs));
      if (we) check("bank_wdata", 32'(bank_wdata), 32'(wd));
      @(negedge Clock);
      check("ack_latency", 32'(bus.ack), 32'(1) << id);
      check("reg_ce_resp", 32'(reg_ce), 0);
      check("reg_cs_resp", 32'(reg_cs), 32'hFF);
      bus.req[id] = 1'b0;
      @(negedge Clock);
      check("grant_clear", 32'(bus.grant), 0);
      check("ack_clear", 32'(bus.ack), 0);
   endtask

   initial begin
      int n;
      Reset         = 1'b1;
      Tick          = 1'b1;
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
`ifdef REG_BANK_PRESET_EN
      preset_req    = 1'b0;
`endif
      for (int r = 0; r < NG; r++) mem[r] = '0;
      repeat (2) @(negedge Clock);
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_rdata", 32'(bus.rdata), 0);
      check("rst_bank_wdata", 32'(bank_wdata), 0);
      check("rst_reg_cs", 32'(reg_cs), 32'hFF);
      check("rst_reg_ce", 32'(reg_ce), 0);
      check("rst_reg_pre", 32'(reg_pre), 0);
      Reset = 1'b0;

      txn(0, 1'b1, 4'd3,  8'hA5, 8'h00, 8'h08, 8'hFF);
      txn(2, 1'b0, 4'd3,  8'h00, 8'hA5, 8'h00, 8'hF7);
      txn(1, 1'b1, 4'd5,  8'h3C, 8'h00, 8'h20, 8'hFF);
      check("rdata_hold", 32'(bus.rdata), 32'hA5);
      txn(3, 1'b0, 4'd5,  8'h00, 8'h3C, 8'h00, 8'hDF);
      txn(0, 1'b0, 4'd9,  8'h00, 8'h00, 8'h00, 8'hFF);
      txn(1, 1'b1, 4'd12, 8'hEE, 8'h00, 8'h00, 8'hFF);
      check("rdata_after_bad_write", 32'(bus.rdata), 0);

      // all four requesting from reset: order 0,1,2,3,0, acks 3 cycles apart
      Reset = 1'b1;
      @(negedge Clock);
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i), 8'(8'h10 + i));
      sb.push_back('{0, 1'b0, 8'h00});
      sb.push_back('{1, 1'b0, 8'h00});
      sb.push_back('{2, 1'b0, 8'h00});
      sb.push_back('{3, 1'b0, 8'h00});
      sb.push_back('{0, 1'b0, 8'h00});
      Reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            @(negedge Clock);
            n++;
         end while (bus.ack == '0 && n < 20);
         if (bus.ack == '0) begin
            checks++;
            errors++;
            $display("FAIL rr_ack_timeout: got no ack after %0d cycles expected ack %0d", n, k);
         end else begin
            check("rr_ack_spacing", 32'(n), (k == 0) ? 2 : 3);
         end
         if (k == 4) bus.req = '0;
      end
      @(negedge Clock);

      // Tick toggling during a write
      sb.push_back('{0, 1'b0, 8'h00});
      set_req(0, 1'b1, 4'd2, 8'h77);
      @(negedge Clock);
      check("tick_grant", 32'(bus.grant), 1);
      check("tick_ce_a", 32'(reg_ce), 32'h04);
      Tick = 1'b0;
      @(negedge Clock);
      check("tick_ce_hold", 32'(reg_ce), 32'h04);
      check("tick_ack_none", 32'(bus.ack), 0);
      Tick = 1'b1;
      @(negedge Clock);
      check("tick_ce_done", 32'(reg_ce), 0);
      check("tick_ack", 32'(bus.ack), 1);
      Tick = 1'b0;
      @(negedge Clock);
      check("tick_ack_hold", 32'(bus.ack), 1);
      Tick = 1'b1;
      bus.req[0] = 1'b0;
      @(negedge Clock);
      check("tick_ack_clear", 32'(bus.ack), 0);
      check("tick_grant_clear", 32'(bus.grant), 0);
      txn(3, 1'b0, 4'd2, 8'h00, 8'h77, 8'h00, 8'hFB);

      // reset while in ACCESS
      set_req(1, 1'b1, 4'd4, 8'h99);
      @(negedge Clock);
      check("mid_ce", 32'(reg_ce), 32'h10);
      Reset = 1'b1;
      #1;
      check("mid_rst_ce", 32'(reg_ce), 0);
      check("mid_rst_cs", 32'(reg_cs), 32'hFF);
      check("mid_rst_grant", 32'(bus.grant), 0);
      check("mid_rst_ack", 32'(bus.ack), 0);
      bus.req = '0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check("mid_rst_no_ack", 32'(bus.ack), 0);

`ifdef REG_BANK_PRESET_EN
      preset_req = 1'b1;
      set_req(1, 1'b1, 4'd6, 8'h42);
      sb.push_back('{1, 1'b0, 8'h00});
      @(negedge Clock);
      check("pre_pulse", 32'(reg_pre), 1);
      check("pre_grant", 32'(bus.grant), 0);
      preset_req = 1'b0;
      @(negedge Clock);
      check("pre_done", 32'(reg_pre), 0);
      @(negedge Clock);
      check("pre_then_grant", 32'(bus.grant), 32'h2);
      check("pre_then_ce", 32'(reg_ce), 32'h40);
      @(negedge Clock);
      check("pre_then_ack", 32'(bus.ack), 32'h2);
      bus.req[1] = 1'b0;
      @(negedge Clock);
      txn(2, 1'b0, 4'd0, 8'h00, 8'hFF, 8'h00, 8'hFE);
`else
      check("reg_pre_tied", 32'(reg_pre), 0);
`endif

      repeat (3) @(negedge Clock);
      check("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
